param_bank_decoder: RTL and testbench
=====================================

Name: param_bank_decoder

Overview:
Generalised successor of the single-purpose control-parameter decoder in the network wrapper. It receives 32-bit command words from the port-1 command decoder and stages writes into a bank of NUM_PARAMS shadow registers. On commit it transfers them atomically into active registers, with per-parameter update pulses. Parameters marked locked may only be committed while the DAC is stopped. Each command receives exactly one ack, nak or err pulse back to the port decoder.

Parameters:
NUM_PARAMS, 8, number of parameter registers (1..256)
PARAM_WIDTH, 27, width of each parameter (1..32)
DATA_WIDTH, 32, width of received_data
LOCK_MASK, {NUM_PARAMS{1'b0}}, bit i=1: param i committable only when DAC_stopped=1
TIMEOUT_CYCLES, 1250, max cycles from WRITE header to its data word (10 us at 125 MHz)

Ports:
clk  in  1  125 MHz rx_xcvr_clk domain
reset_n  in  1  asynchronous, active-low reset
received_data  in  DATA_WIDTH  command/data word from port decoder
received_valid  in  1  one-cycle strobe qualifying received_data
wipe_settings  in  1  one-cycle strobe: clear shadow+active to 0
DAC_stopped  in  1  level, DAC idle
param_values  out  NUM_PARAMS*PARAM_WIDTH  active values, param i at [i*PARAM_WIDTH +: PARAM_WIDTH]
param_update  out  NUM_PARAMS  one-cycle pulse per committed param
ack  out  1  one-cycle success pulse
nak  out  1  one-cycle refused pulse (lock violation)
err  out  1  one-cycle malformed/timeout pulse
all_written  out  1  level: every param committed at least once since reset/wipe
busy  out  1  high while not in IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0, shadow/active/dirty/written bits 0, state IDLE.
- Header word: [31:24] opcode, [23:16] addr, [15:0] ignored. Opcodes: 0x01 WRITE, 0x02 COMMIT, 0x03 DISCARD (clear dirty bits). Any other opcode -> err.
- IDLE, valid header:
  - WRITE with addr<NUM_PARAMS -> latch addr, load timeout counter, go to WAIT_DATA, no response yet.
  - WRITE with addr>=NUM_PARAMS -> err, stay IDLE.
  - COMMIT -> go to COMMIT.
  - DISCARD -> dirty=0, ack.
- WAIT_DATA:
  - Next valid word is data. Upper bits [DATA_WIDTH-1:PARAM_WIDTH] must equal sign extension of bit PARAM_WIDTH-1; otherwise err and shadow unchanged.
  - Valid data -> shadow[addr]=data[PARAM_WIDTH-1:0], dirty[addr]=1, ack.
  - Either way return to IDLE.
  - Counter reaches 0 with no valid word -> err, IDLE, shadow unchanged.
- COMMIT (one cycle, evaluates dirty, LOCK_MASK, DAC_stopped):
  - If (dirty & LOCK_MASK)!=0 and DAC_stopped=0 -> nak; nothing committed, dirty retained.
  - Else: for each dirty i, active[i]=shadow[i], param_update[i]=1, written[i]=1; dirty=0; ack.
  - COMMIT with dirty=0 -> ack, no update pulses.
  - Return to IDLE.
- Latency: response asserted on the cycle after the deciding word, or at COMMIT evaluation. param_update coincides with ack. param_values changes on the same edge.
- valid while in COMMIT is ignored (port decoder serialises on ack/nak/err).
- wipe_settings has priority over everything in the same cycle: shadow/active/dirty/written cleared, state IDLE, any pending command abandoned with no response, no update pulses.
- all_written = &written; combinationally derived from registers.
- Exactly one of ack/nak/err per command; never two asserted together.

Decomposition:
- Shared package param_bank_pkg: opcode constants (OP_WRITE, OP_COMMIT, OP_DISCARD), header field positions, state encoding.
- Sub-module param_bank_regs: shadow/active arrays, dirty/written vectors, commit and wipe logic.
- Top level holds the FSM, timeout counter and width check.

Test Plan:
- WRITE addr 2 then data 0x0000_1234, COMMIT -> ack, ack; param_values[2]=0x1234; param_update=8'b0000_0100; all_written=0.
- LOCK_MASK=8'h01, DAC_stopped=0, WRITE addr 0 data 5, COMMIT -> nak, param 0 unchanged. Set DAC_stopped=1, COMMIT -> ack, param_update[0]=1, value 5.
- WRITE addr 1, data 0x0800_0000 (PARAM_WIDTH=27, bit 27 set, not a sign extension) -> err, shadow unchanged. Data 0xFFFF_FFFF -> ack, value 0x7FF_FFFF.
- WRITE addr 3, no data for 1250 cycles -> err exactly at timeout, busy drops. WRITE addr 9 -> immediate err. Opcode 0x7F -> err.
- Write and commit all 8 params -> all_written rises on the final commit. wipe_settings mid-WAIT_DATA -> all values 0, all_written=0, no response pulse.
- Assert reset_n low mid-WAIT_DATA -> outputs 0 asynchronously. After release, normal WRITE/COMMIT succeeds.

Source files
------------

// File: rtl/param_bank_pkg.sv
// Shared constants for the parameter-bank command decoder: opcodes, header
// field positions, FSM and response encodings.
package param_bank_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_COMMIT  = 8'h02;
  localparam logic [7:0] OP_DISCARD = 8'h03;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_ACK,
    RSP_NAK,
    RSP_ERR
  } rsp_t;

endpackage

// File: rtl/param_bank_decoder_if.sv
// Command word stream from the port decoder and the single-pulse
// ack/nak/err reply that serialises it.
interface param_bank_decoder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] received_data;
  logic                  received_valid;
  logic                  ack;
  logic                  nak;
  logic                  err;

  modport master (output received_data, received_valid, input ack, nak, err);
  modport slave  (input received_data, received_valid, output ack, nak, err);
endinterface

// File: rtl/param_bank_regs.sv
// Shadow/active parameter storage with dirty and written tracking; commit
// moves every dirty shadow into its active register in one edge.
module param_bank_regs #(
  parameter int                    NUM_PARAMS  = 8,
  parameter int                    PARAM_WIDTH = 27,
  parameter int                    ADDR_W      = 3,
  parameter logic [NUM_PARAMS-1:0] LOCK_MASK   = '0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              wipe,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [PARAM_WIDTH-1:0]            wr_data,
  input  logic                              discard,
  input  logic                              commit,
  input  logic                              dac_stopped,
  output logic                              commit_blocked,
  output logic [NUM_PARAMS*PARAM_WIDTH-1:0] param_values,
  output logic [NUM_PARAMS-1:0]             param_update,
  output logic                              all_written
);

  logic [NUM_PARAMS-1:0][PARAM_WIDTH-1:0] shadow;
  logic [NUM_PARAMS-1:0][PARAM_WIDTH-1:0] active;
  logic [NUM_PARAMS-1:0]                  dirty;
  logic [NUM_PARAMS-1:0]                  written;

  assign commit_blocked = (|(dirty & LOCK_MASK)) && !dac_stopped;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow       <= '0;
      dirty        <= '0;
      written      <= '0;
      param_update <= '0;
    end else if (wipe) begin
      shadow       <= '0;
      dirty        <= '0;
      written      <= '0;
      param_update <= '0;
    end else begin
      param_update <= '0;
      if (wr_en) begin
        shadow[wr_addr] <= wr_data;
        dirty[wr_addr]  <= 1'b1;
      end
      if (discard) dirty <= '0;
      if (commit) begin
        param_update <= dirty;
        written      <= written | dirty;
        dirty        <= '0;
      end
    end
  end

  // Per-parameter active register; only dirty entries move on commit.
  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_param
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                active[i] <= '0;
      else if (wipe)               active[i] <= '0;
      else if (commit && dirty[i]) active[i] <= shadow[i];
    end
  end

  assign param_values = active;
  assign all_written  = &written;

endmodule

// File: rtl/param_bank_decoder.sv
// Command FSM for the parameter bank: header decode, write-data timeout and
// sign-extension check, commit arbitration against the DAC lock.
module param_bank_decoder
  import param_bank_pkg::*;
#(
  parameter int                    NUM_PARAMS     = 8,
  parameter int                    PARAM_WIDTH    = 27,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [NUM_PARAMS-1:0] LOCK_MASK      = {NUM_PARAMS{1'b0}},
  parameter int                    TIMEOUT_CYCLES = 1250
) (
  input  logic                              clk,
  input  logic                              reset_n,
  param_bank_decoder_if.slave               cmd,
  input  logic                              wipe_settings,
  input  logic                              DAC_stopped,
  output logic [NUM_PARAMS*PARAM_WIDTH-1:0] param_values,
  output logic [NUM_PARAMS-1:0]             param_update,
  output logic                              all_written,
  output logic                              busy
);

  localparam int AW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state_q, state_d;
  rsp_t            rsp_q, rsp_d;
  logic [AW-1:0]   addr_q;
  logic [CW-1:0]   cnt_q;
  logic            load_cnt, dec_cnt;
  logic            wr_en, discard, commit, commit_blocked;
  logic            ext_ok, addr_ok;
  logic [7:0]      opcode;

  assign opcode  = cmd.received_data[OP_MSB:OP_LSB];
  assign addr_ok = {1'b0, cmd.received_data[ADDR_MSB:ADDR_LSB]} < 9'(NUM_PARAMS);

  // Data word is legal only if the bits above the parameter are a pure sign extension.
  if (DATA_WIDTH > PARAM_WIDTH) begin : g_ext
    assign ext_ok = cmd.received_data[DATA_WIDTH-1:PARAM_WIDTH] ==
                    {(DATA_WIDTH-PARAM_WIDTH){cmd.received_data[PARAM_WIDTH-1]}};
  end else begin : g_noext
    assign ext_ok = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rsp_d    = RSP_NONE;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    wr_en    = 1'b0;
    discard  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd.received_valid) begin
        case (opcode)
          OP_WRITE: if (addr_ok) begin
            state_d  = ST_WAIT_DATA;
            load_cnt = 1'b1;
          end else begin
            rsp_d = RSP_ERR;
          end
          OP_COMMIT:  state_d = ST_COMMIT;
          OP_DISCARD: begin
            discard = 1'b1;
            rsp_d   = RSP_ACK;
          end
          default:    rsp_d = RSP_ERR;
        endcase
      end
      ST_WAIT_DATA: begin
        if (cmd.received_valid) begin
          state_d = ST_IDLE;
          if (ext_ok) begin
            wr_en = 1'b1;
            rsp_d = RSP_ACK;
          end else begin
            rsp_d = RSP_ERR;
          end
        end else if (cnt_q <= CW'(1)) begin
          state_d = ST_IDLE;
          rsp_d   = RSP_ERR;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (commit_blocked) begin
          rsp_d = RSP_NAK;
        end else begin
          commit = 1'b1;
          rsp_d  = RSP_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Wipe abandons whatever is in flight, silently.
    if (wipe_settings) begin
      state_d  = ST_IDLE;
      rsp_d    = RSP_NONE;
      load_cnt = 1'b0;
      dec_cnt  = 1'b0;
      wr_en    = 1'b0;
      discard  = 1'b0;
      commit   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rsp_q   <= RSP_NONE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      if (load_cnt) begin
        addr_q <= cmd.received_data[ADDR_LSB +: AW];
        cnt_q  <= CW'(TIMEOUT_CYCLES);
      end else if (dec_cnt) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign cmd.ack = (rsp_q == RSP_ACK);
  assign cmd.nak = (rsp_q == RSP_NAK);
  assign cmd.err = (rsp_q == RSP_ERR);
  assign busy    = (state_q != ST_IDLE);

  param_bank_regs #(
    .NUM_PARAMS  (NUM_PARAMS),
    .PARAM_WIDTH (PARAM_WIDTH),
    .ADDR_W      (AW),
    .LOCK_MASK   (LOCK_MASK)
  ) u_regs (
    .clk            (clk),
    .reset_n        (reset_n),
    .wipe           (wipe_settings),
    .wr_en          (wr_en),
    .wr_addr        (addr_q),
    .wr_data        (cmd.received_data[PARAM_WIDTH-1:0]),
    .discard        (discard),
    .commit         (commit),
    .dac_stopped    (DAC_stopped),
    .commit_blocked (commit_blocked),
    .param_values   (param_values),
    .param_update   (param_update),
    .all_written    (all_written)
  );

endmodule

// File: tb/tb_param_bank_decoder.sv
// Randomised + directed bench for param_bank_decoder against a value-level
// model of the shadow/active bank.
module tb_param_bank_decoder;
  import param_bank_pkg::*;

  localparam int             NP = 8;
  localparam int             PW = 27;
  localparam int             DW = 32;
  localparam int             TO = 1250;
  localparam logic [NP-1:0]  LM = 8'h01;
  localparam logic [2:0] R_NONE = 3'b000, R_ACK = 3'b100, R_NAK = 3'b010, R_ERR = 3'b001;

  logic clk = 1'b0, reset_n = 1'b0, wipe = 1'b0, dac = 1'b0;
  logic [NP*PW-1:0] pv;
  logic [NP-1:0]    pu;
  logic             aw, busy;

  param_bank_decoder_if #(.DATA_WIDTH(DW)) bus();

  param_bank_decoder #(
    .NUM_PARAMS(NP), .PARAM_WIDTH(PW), .DATA_WIDTH(DW),
    .LOCK_MASK(LM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd(bus), .wipe_settings(wipe),
    .DAC_stopped(dac), .param_values(pv), .param_update(pu),
    .all_written(aw), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic [PW-1:0] m_shadow [NP];
  logic [PW-1:0] m_active [NP];
  bit            m_dirty  [NP];
  bit            m_written[NP];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pval(int i);
    return pv[i*PW +: PW];
  endfunction

  function automatic logic [2:0] rsp();
    return {bus.ack, bus.nak, bus.err};
  endfunction

  function automatic logic [31:0] hdr(logic [7:0] op, int a);
    logic [15:0] junk;
    junk = 16'($urandom());
    return {op, 8'(a), junk};
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NP; i++) begin
      m_shadow[i] = '0; m_active[i] = '0; m_dirty[i] = 0; m_written[i] = 0;
    end
  endtask

  function automatic bit m_all();
    for (int i = 0; i < NP; i++) if (!m_written[i]) return 0;
    return 1;
  endfunction

  // Data is legal iff, read as a signed 32-bit number, it fits in PW signed bits.
  task automatic m_data(int a, logic [31:0] d, output logic [2:0] e);
    int v;
    v = int'(d);
    if (v >= -(1 << (PW-1)) && v < (1 << (PW-1))) begin
      m_shadow[a] = d[PW-1:0];
      m_dirty[a]  = 1;
      e = R_ACK;
    end else e = R_ERR;
  endtask

  task automatic m_commit(output logic [2:0] e, output logic [NP-1:0] em);
    bit blocked;
    blocked = 0;
    em = '0;
    for (int i = 0; i < NP; i++) if (m_dirty[i] && LM[i] && !dac) blocked = 1;
    if (blocked) e = R_NAK;
    else begin
      e = R_ACK;
      for (int i = 0; i < NP; i++) if (m_dirty[i]) begin
        m_active[i] = m_shadow[i]; m_written[i] = 1; em[i] = 1'b1; m_dirty[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(logic [31:0] w);
    bus.received_data  = w;
    bus.received_valid = 1'b1;
    tick();
    bus.received_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [2:0] r, output logic [NP-1:0] m);
    r = R_NONE;
    m = pu;
    for (int k = 0; k < 4; k++) begin
      if (rsp() != R_NONE) begin r = rsp(); m = pu; return; end
      tick();
    end
  endtask

  task automatic check_state(string tag);
    for (int i = 0; i < NP; i++)
      chk($sformatf("%s_val%0d", tag, i), 64'(pval(i)), 64'(m_active[i]));
    chk({tag, "_allw"}, 64'(aw), 64'(m_all()));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_write(string tag, int a, logic [31:0] d, int gap);
    logic [2:0] r, e;
    logic [NP-1:0] m;
    send(hdr(OP_WRITE, a));
    if (a >= NP) begin
      wait_rsp(r, m);
      chk({tag, "_badaddr"}, 64'(r), 64'(R_ERR));
      check_state(tag);
      return;
    end
    chk({tag, "_hdr_quiet"}, 64'(rsp()), 64'(R_NONE));
    chk({tag, "_hdr_busy"}, 64'(busy), 64'd1);
    repeat (gap) tick();
    send(d);
    m_data(a, d, e);
    wait_rsp(r, m);
    chk({tag, "_rsp"}, 64'(r), 64'(e));
    chk({tag, "_upd"}, 64'(m), 64'd0);
    check_state(tag);
  endtask

  task automatic do_commit(string tag);
    logic [2:0] r, e;
    logic [NP-1:0] m, em;
    send(hdr(OP_COMMIT, 0));
    m_commit(e, em);
    wait_rsp(r, m);
    chk({tag, "_rsp"}, 64'(r), 64'(e));
    chk({tag, "_upd"}, 64'(m), 64'(em));
    check_state(tag);
  endtask

  task automatic do_single(string tag, logic [7:0] op);
    logic [2:0] r;
    logic [NP-1:0] m;
    send(hdr(op, $urandom_range(0, 255)));
    if (op == OP_DISCARD) for (int i = 0; i < NP; i++) m_dirty[i] = 0;
    wait_rsp(r, m);
    chk({tag, "_rsp"}, 64'(r), 64'((op == OP_DISCARD) ? R_ACK : R_ERR));
    check_state(tag);
  endtask

  function automatic logic [31:0] rand_data();
    logic [PW-1:0] v;
    logic [31:0]   d;
    v = PW'($urandom());
    d = $urandom();
    if ($urandom_range(0, 1) == 1) d = {{(32-PW){v[PW-1]}}, v};
    return d;
  endfunction

  initial begin
    int n;
    logic [2:0] r, e;
    logic [NP-1:0] m;
    bus.received_data  = '0;
    bus.received_valid = 1'b0;
    m_clear();

    #1;
    check_state("rst");
    chk("rst_rsp", 64'(rsp()), 64'(R_NONE));
    chk("rst_upd", 64'(pu), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Basic write and commit of an unlocked parameter.
    do_write("t1w", 2, 32'h0000_1234, 0);
    do_commit("t1c");
    chk("t1_val2", 64'(pval(2)), 64'h1234);

    // Locked parameter refused until the DAC stops.
    dac = 1'b0;
    do_write("t2w", 0, 32'd5, 0);
    do_commit("t2nak");
    dac = 1'b1;
    do_commit("t2ack");
    chk("t2_val0", 64'(pval(0)), 64'd5);

    // Width check on the data word.
    do_write("t3bad", 1, 32'h0800_0000, 1);
    do_write("t3neg", 1, 32'hFFFF_FFFF, 2);
    do_commit("t3c");
    chk("t3_val1", 64'(pval(1)), 64'h7FF_FFFF);

    // Timeout with no data word.
    send(hdr(OP_WRITE, 3));
    n = 0;
    while (rsp() == R_NONE && n < TO + 10) begin tick(); n++; end
    chk("to_rsp", 64'(rsp()), 64'(R_ERR));
    chk("to_cycles", 64'(n), 64'(TO));
    check_state("to");

    // Data arriving on the last permitted cycle is accepted.
    send(hdr(OP_WRITE, 3));
    repeat (TO - 1) tick();
    send(32'd77);
    m_data(3, 32'd77, e);
    wait_rsp(r, m);
    chk("to_edge_rsp", 64'(r), 64'(e));
    do_commit("to_edge_c");

    do_write("badaddr", 9, 32'd0, 0);
    do_single("badop", 8'h7F);
    do_single("discard", OP_DISCARD);

    // Fill every parameter; all_written rises only with the last commit.
    for (int i = 0; i < NP; i++) begin
      do_write("aw_w", i, 32'(i * 3 + 1), 0);
      do_commit("aw_c");
      chk("aw_level", 64'(aw), 64'((i == NP - 1) ? 1 : 0));
    end

    // Wipe in the middle of a pending write: silent, everything cleared.
    send(hdr(OP_WRITE, 4));
    tick();
    wipe = 1'b1;
    tick();
    wipe = 1'b0;
    m_clear();
    for (int k = 0; k < 3; k++) begin
      chk("wipe_quiet", 64'(rsp()), 64'(R_NONE));
      chk("wipe_upd", 64'(pu), 64'd0);
      tick();
    end
    check_state("wipe");

    // Wipe wins over a same-cycle header.
    wipe = 1'b1;
    send(hdr(OP_WRITE, 5));
    wipe = 1'b0;
    chk("wipe_prio_busy", 64'(busy), 64'd0);
    chk("wipe_prio_rsp", 64'(rsp()), 64'(R_NONE));

    // Randomised command mix.
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_write("rw", $urandom_range(0, 9), rand_data(), $urandom_range(0, 3));
        5, 6:          do_commit("rc");
        7:             do_single("rd", OP_DISCARD);
        8:             do_single("rop", 8'($urandom_range(4, 255)));
        default:       dac = 1'($urandom_range(0, 1));
      endcase
    end

    // Asynchronous reset during a pending write.
    dac = 1'b1;
    do_write("pre_rst", 6, 32'h15, 0);
    do_commit("pre_rst_c");
    send(hdr(OP_WRITE, 6));
    #3 reset_n = 1'b0;
    #1;
    m_clear();
    check_state("arst");
    chk("arst_rsp", 64'(rsp()), 64'(R_NONE));
    chk("arst_upd", 64'(pu), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    do_write("post_rst_w", 6, 32'h2A, 0);
    do_commit("post_rst_c");
    chk("post_rst_val6", 64'(pval(6)), 64'h2A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
